// File: rtl/gol_pkg.sv
// Shared definitions for the generation scheduler: state encoding and default widths.
package gol_pkg;

    localparam int GEN_W_DEF    = 16;
    localparam int PERIOD_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_START      = 2'd1,
        ST_WAIT_DONE  = 2'd2,
        ST_WAIT_FRAME = 2'd3
    } sched_state_e;

endpackage

// File: rtl/frame_divider.sv
// Counts frame_start pulses while run is high and fires frame_tick every period frames.
module frame_divider
    import gol_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start,
    input  logic                run,
    input  logic [PERIOD_W-1:0] period,
    output logic                frame_tick,
    output logic [PERIOD_W-1:0] fcnt
);

    localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

    logic [PERIOD_W-1:0] fcnt_q;
    logic [PERIOD_W-1:0] fcnt_d;
    logic [PERIOD_W-1:0] period_m1;

    always_comb begin
        // A period of 0 behaves like 1, so the terminal count is 0 in both cases.
        period_m1  = (period == '0) ? '0 : period - ONE;
        fcnt_d     = fcnt_q;
        frame_tick = 1'b0;
        if (!run) begin
            fcnt_d = '0;
        end else if (frame_start) begin
            if (fcnt_q >= period_m1) begin
                fcnt_d     = '0;
                frame_tick = 1'b1;
            end else begin
                fcnt_d = fcnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign fcnt = fcnt_q;

endmodule

// File: rtl/gen_scheduler.sv
// Sequences one update-engine run per trigger and swaps display buffers on the next frame.
//
// state         | meaning
// ST_IDLE       | waiting for a trigger or a pending request
// ST_START      | upd_start asserted for this single cycle
// ST_WAIT_DONE  | engine is writing the back buffer
// ST_WAIT_FRAME | back buffer complete; swap at next frame_start
module gen_scheduler
    import gol_pkg::*;
#(
    parameter int GEN_W    = GEN_W_DEF,
    parameter int PERIOD_W = PERIOD_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start,
    input  logic                run,
    input  logic                step,
    input  logic [PERIOD_W-1:0] period,
    input  logic                upd_done,
    input  logic                clr_overrun,
    output logic                upd_start,
    output logic                busy,
    output logic                buf_sel,
    output logic                swap,
    output logic [GEN_W-1:0]    gen_count,
    output logic                overrun
);

    localparam logic [GEN_W-1:0] GEN_ONE = GEN_W'(1);

    sched_state_e        state_q, state_d;
    logic                pending_q, pending_d;
    logic                overrun_q, overrun_d;
    logic                buf_sel_q, buf_sel_d;
    logic                swap_q, swap_d;
    logic [GEN_W-1:0]    gen_count_q, gen_count_d;
    logic                frame_tick;
    logic                trigger;
    logic                overrun_set;
    logic [PERIOD_W-1:0] fcnt;

    frame_divider #(
        .PERIOD_W (PERIOD_W)
    ) u_div (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .run         (run),
        .period      (period),
        .frame_tick  (frame_tick),
        .fcnt        (fcnt)
    );

    assign trigger = frame_tick | step;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        overrun_d   = overrun_q;
        buf_sel_d   = buf_sel_q;
        gen_count_d = gen_count_q;
        swap_d      = 1'b0;
        overrun_set = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (trigger || pending_q) begin
                    state_d   = ST_START;
                    pending_d = 1'b0;
                end
            end
            ST_START: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (upd_done) begin
                    state_d = ST_WAIT_FRAME;
                end
            end
            ST_WAIT_FRAME: begin
                if (frame_start) begin
                    state_d     = ST_IDLE;
                    swap_d      = 1'b1;
                    buf_sel_d   = ~buf_sel_q;
                    gen_count_d = gen_count_q + GEN_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // One request can wait behind the running generation; a second is lost.
        if (trigger && (state_q != ST_IDLE)) begin
            if (!pending_q) begin
                pending_d = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end

        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
            buf_sel_q   <= 1'b0;
            swap_q      <= 1'b0;
            gen_count_q <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            buf_sel_q   <= buf_sel_d;
            swap_q      <= swap_d;
            gen_count_q <= gen_count_d;
        end
    end

    assign upd_start = (state_q == ST_START);
    assign busy      = (state_q != ST_IDLE);
    assign buf_sel   = buf_sel_q;
    assign swap      = swap_q;
    assign gen_count = gen_count_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_gen_scheduler.sv
// Directed bench for gen_scheduler; a 4-bit-counter copy shares the stimulus to reach wrap quickly.
module tb_gen_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_start = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [7:0]  period = 8'd0;
    logic        upd_done = 1'b0;
    logic        clr_overrun = 1'b0;

    logic        upd_start, busy, buf_sel, swap, overrun;
    logic [15:0] gen_count;
    logic        w_upd_start, w_busy, w_buf_sel, w_swap, w_overrun;
    logic [3:0]  w_gen_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gen_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .run         (run),
        .step        (step),
        .period      (period),
        .upd_done    (upd_done),
        .clr_overrun (clr_overrun),
        .upd_start   (upd_start),
        .busy        (busy),
        .buf_sel     (buf_sel),
        .swap        (swap),
        .gen_count   (gen_count),
        .overrun     (overrun)
    );

    gen_scheduler #(.GEN_W(4)) dut_w (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .run         (run),
        .step        (step),
        .period      (period),
        .upd_done    (upd_done),
        .clr_overrun (clr_overrun),
        .upd_start   (w_upd_start),
        .busy        (w_busy),
        .buf_sel     (w_buf_sel),
        .swap        (w_swap),
        .gen_count   (w_gen_count),
        .overrun     (w_overrun)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic frame();
        frame_start = 1'b1; cyc(); frame_start = 1'b0;
    endtask

    task automatic stepp();
        step = 1'b1; cyc(); step = 1'b0;
    endtask

    task automatic done();
        upd_done = 1'b1; cyc(); upd_done = 1'b0;
    endtask

    task automatic do_reset();
        frame_start = 0; step = 0; upd_done = 0; clr_overrun = 0; run = 0;
        rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    endtask

    task automatic test_reset();
        frame_start = 0; step = 0; upd_done = 0; clr_overrun = 0; run = 0;
        rst = 1'b1; cyc();
        total++;
        if ({upd_start, busy, buf_sel, swap, overrun} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=00000", {upd_start, busy, buf_sel, swap, overrun});
        end
        total++;
        if (gen_count !== 16'd0) begin
            bad++; $display("FAIL reset_gen got=%0d want=0", gen_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_period3();
        do_reset();
        period = 8'd3; run = 1'b1; idle(2);
        frame(); idle(5);
        frame();
        total++;
        if (upd_start !== 1'b0) begin
            bad++; $display("FAIL p3_early_start got=%b want=0", upd_start);
        end
        idle(5);
        for (int g = 1; g <= 2; g++) begin
            frame();
            total++;
            if (upd_start !== 1'b1 || busy !== 1'b1) begin
                bad++; $display("FAIL p3_start gen=%0d got=%b%b want=11", g, upd_start, busy);
            end
            idle(99);
            done(); idle(5);
            total++;
            if (swap !== 1'b0 || buf_sel !== 1'(g - 1)) begin
                bad++; $display("FAIL p3_preswap gen=%0d swap=%b buf_sel=%b", g, swap, buf_sel);
            end
            frame();
            total++;
            if (swap !== 1'b1 || buf_sel !== 1'(g) || gen_count !== 16'(g)) begin
                bad++; $display("FAIL p3_swap gen=%0d got swap=%b sel=%b cnt=%0d want 1 %0d %0d",
                                g, swap, buf_sel, gen_count, g % 2, g);
            end
            idle(5);
            frame();
            total++;
            if (upd_start !== 1'b0 || swap !== 1'b0) begin
                bad++; $display("FAIL p3_mid_frame gen=%0d start=%b swap=%b want 0 0", g, upd_start, swap);
            end
            idle(5);
        end
    endtask

    task automatic test_step();
        do_reset();
        period = 8'd3; run = 1'b0;
        stepp();
        total++;
        if (upd_start !== 1'b1) begin
            bad++; $display("FAIL step_start got=%b want=1", upd_start);
        end
        idle(3); done(); frame();
        total++;
        if (swap !== 1'b1 || buf_sel !== 1'b1 || gen_count !== 16'd1) begin
            bad++; $display("FAIL step_swap got swap=%b sel=%b cnt=%0d want 1 1 1", swap, buf_sel, gen_count);
        end
        total++;
        if (dut.u_div.fcnt !== 8'd0) begin
            bad++; $display("FAIL step_fcnt got=%0d want=0", dut.u_div.fcnt);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        period = 8'd0; run = 1'b1;
        frame();
        total++;
        if (upd_start !== 1'b1) begin
            bad++; $display("FAIL ovr_first_start got=%b want=1", upd_start);
        end
        idle(19);
        frame();
        total++;
        if (overrun !== 1'b0) begin
            bad++; $display("FAIL ovr_pending got=%b want=0", overrun);
        end
        idle(9); done(); idle(9);
        frame();
        total++;
        if (swap !== 1'b1 || overrun !== 1'b1 || upd_start !== 1'b0) begin
            bad++; $display("FAIL ovr_third got swap=%b ovr=%b start=%b want 1 1 0", swap, overrun, upd_start);
        end
        cyc();
        total++;
        if (upd_start !== 1'b1) begin
            bad++; $display("FAIL ovr_pending_start got=%b want=1", upd_start);
        end
        clr_overrun = 1'b1; cyc(); clr_overrun = 1'b0;
        total++;
        if (overrun !== 1'b0) begin
            bad++; $display("FAIL ovr_clear got=%b want=0", overrun);
        end
        stepp();
        step = 1'b1; clr_overrun = 1'b1; cyc(); step = 1'b0; clr_overrun = 1'b0;
        total++;
        if (overrun !== 1'b1) begin
            bad++; $display("FAIL ovr_set_wins got=%b want=1", overrun);
        end
        clr_overrun = 1'b1; cyc(); clr_overrun = 1'b0;
        total++;
        if (overrun !== 1'b0) begin
            bad++; $display("FAIL ovr_clear2 got=%b want=0", overrun);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        run = 1'b0;
        stepp(); idle(2);
        upd_done = 1'b1; frame_start = 1'b1; cyc(); upd_done = 1'b0; frame_start = 1'b0;
        cyc();
        total++;
        if (swap !== 1'b0 || buf_sel !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL same_no_swap got swap=%b sel=%b busy=%b want 0 0 1", swap, buf_sel, busy);
        end
        idle(3); frame();
        total++;
        if (swap !== 1'b1 || buf_sel !== 1'b1) begin
            bad++; $display("FAIL same_late_swap got swap=%b sel=%b want 1 1", swap, buf_sel);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run = 1'b0;
        stepp(); idle(2); stepp();
        rst = 1'b1; cyc(); rst = 1'b0;
        total++;
        if ({upd_start, busy, buf_sel, swap, overrun} !== 5'b0 || gen_count !== 16'd0) begin
            bad++; $display("FAIL rstmid_outputs got=%b cnt=%0d want=00000 0",
                            {upd_start, busy, buf_sel, swap, overrun}, gen_count);
        end
        idle(2);
        total++;
        if (upd_start !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_pending got start=%b busy=%b want 0 0", upd_start, busy);
        end
        done(); frame();
        total++;
        if (swap !== 1'b0 || gen_count !== 16'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_late_done got swap=%b cnt=%0d busy=%b want 0 0 0", swap, gen_count, busy);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        run = 1'b0;
        for (int g = 0; g < 15; g++) begin
            stepp(); cyc(); done(); frame();
        end
        total++;
        if (w_gen_count !== 4'hF) begin
            bad++; $display("FAIL wrap_pre got=%0d want=15", w_gen_count);
        end
        stepp(); cyc(); done(); frame();
        total++;
        if (w_gen_count !== 4'h0 || w_swap !== 1'b1) begin
            bad++; $display("FAIL wrap_zero got cnt=%0d swap=%b want 0 1", w_gen_count, w_swap);
        end
        total++;
        if (gen_count !== 16'd16) begin
            bad++; $display("FAIL wrap_wide got=%0d want=16", gen_count);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc();
        test_reset();
        test_period3();
        test_step();
        test_overrun();
        test_same_cycle();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gen_scheduler.md
GEN_SCHEDULER -- requirements
Module: gen_scheduler

Interface
REQ-001 Parameter GEN_W, default 16: width of generation counter.
REQ-002 Parameter PERIOD_W, default 8: width of frames-per-generation setting.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 frame_start  input  1  one-cycle pulse at start of each VGA frame (vertical count wrap).
REQ-006 run  input  1  level; enables automatic generation stepping.
REQ-007 step  input  1  one-cycle pulse; requests a single generation.
REQ-008 period  input  PERIOD_W  frames per generation; 0 treated as 1.
REQ-009 upd_done  input  1  one-cycle pulse from update engine: back buffer fully written.
REQ-010 clr_overrun  input  1  one-cycle pulse; clears overrun.
REQ-011 upd_start  output  1  one-cycle pulse commanding update engine to compute next generation.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 buf_sel  output  1  front-buffer select seen by VGA reader; engine writes ~buf_sel.
REQ-014 swap  output  1  one-cycle pulse coincident with buf_sel toggle.
REQ-015 gen_count  output  GEN_W  completed generations.
REQ-016 overrun  output  1  sticky; a trigger was lost.

Function
REQ-017 Frame divider fcnt (PERIOD_W bits) SHALL count frame_start pulses while run=1, in every state; fcnt held at 0 while run=0.
REQ-018 On frame_start with run=1: if fcnt >= period_eff-1, fcnt<=0 and frame trigger fires; else fcnt<=fcnt+1.
REQ-019 Trigger = frame trigger OR step; both in same cycle count as one trigger.
REQ-020 FSM states SHALL be IDLE, START, WAIT_DONE, WAIT_FRAME.
REQ-021 IDLE: trigger or pending=1 -> START next cycle; pending cleared on that transition.
REQ-022 START: upd_start=1 for exactly this one cycle (Moore); -> WAIT_DONE unconditionally.
REQ-023 WAIT_DONE: upd_done -> WAIT_FRAME; frame_start in same cycle as upd_done does NOT swap.
REQ-024 WAIT_FRAME: on frame_start -> IDLE, swap=1, buf_sel toggles, gen_count increments (wraps to 0 at max) in that same edge.
REQ-025 upd_done outside WAIT_DONE SHALL be ignored.
REQ-026 Trigger while state != IDLE: if pending=0 set pending=1; if pending=1 set overrun=1 and drop the trigger.
REQ-027 Trigger on the WAIT_FRAME->IDLE swap cycle SHALL set pending (subject to REQ-026), producing START one cycle after returning to IDLE.
REQ-028 clr_overrun clears overrun unless a new overrun occurs the same cycle (set wins).
REQ-029 Latency: trigger at IDLE edge t -> upd_start high at t+1.

Reset
REQ-030 rst=1 SHALL force state=IDLE, fcnt=0, pending=0, upd_start=0, swap=0, busy=0, buf_sel=0, gen_count=0, overrun=0 at next clk edge.
REQ-031 Reset mid-generation SHALL abandon the generation with no swap; subsequent upd_done ignored.

Structure
REQ-032 Shared package gol_pkg SHALL hold the FSM state encoding and GEN_W/PERIOD_W defaults.
REQ-033 Frame divider (REQ-017/018) SHALL be a sub-module frame_divider; FSM, pending and overrun stay in gen_scheduler.

Verification
REQ-034 period=3, run=1, engine done 100 cycles after upd_start: upd_start on every 3rd frame_start; swap at following frame_start; gen_count 0->1->2.
REQ-035 run=0, step pulse: upd_start next cycle; upd_done; swap on next frame_start; buf_sel 0->1; fcnt stays 0.
REQ-036 period=0, run=1, engine takes 1.5 frames: frame triggers every frame; pending absorbs one, third trigger sets overrun=1; clr_overrun clears it.
REQ-037 upd_done and frame_start same cycle in WAIT_DONE: no swap that cycle; swap on next frame_start only.
REQ-038 rst asserted in WAIT_DONE with pending=1: all outputs at reset values next edge; late upd_done produces no swap; gen_count stays 0.
REQ-039 gen_count at 16'hFFFF plus one generation: wraps to 0, swap still pulses.
